obi_dmem_bridge: RTL
====================

// Module: obi_dmem_bridge
// PURPOSE
//  Testbench-side data-memory front end. Accepts the core's OBI data request channel (req/gnt/rvalid),
//  injects pseudo-random grant stalls and converts each granted transfer into a single-cycle access on
//  the byte-addressed dual-port RAM's data port (en/addr/wdata/we/be, 1-cycle registered rdata).
//  Flags out-of-range addresses as bus errors and counts transfers and stall cycles for test reporting.
// PARAMETERS
//  ADDR_WIDTH   22       RAM byte-address width; addresses >= 2**ADDR_WIDTH are out of range
//  GNT_STALL_EN 1        1: random grant stalls enabled; 0: grant in the request cycle when possible
//  MAX_STALL    3        max wait cycles before grant (0..15)
//  LFSR_SEED    16'hACE1 stall LFSR reset value; 0 is replaced by 16'h0001
// PORTS
//  clk_i          in   1           clock, all state on rising edge
//  rst_ni         in   1           asynchronous active-low reset
//  data_req_i     in   1           OBI request
//  data_gnt_o     out  1           OBI grant (combinational from state and req)
//  data_addr_i    in   32          byte address
//  data_we_i      in   1           1 = write
//  data_be_i      in   4           byte enables
//  data_wdata_i   in   32          write data
//  data_rvalid_o  out  1           response valid, one per grant
//  data_rdata_o   out  32          read data (0 for writes/errors)
//  data_err_o     out  1           response error (qualified by rvalid)
//  ram_en_o       out  1           RAM port enable
//  ram_addr_o     out  ADDR_WIDTH  RAM byte address = data_addr_i[ADDR_WIDTH-1:0]
//  ram_wdata_o    out  32          = data_wdata_i
//  ram_we_o       out  1           = data_we_i
//  ram_be_o       out  4           = data_be_i
//  ram_rdata_i    in   32          RAM read data, valid 1 cycle after ram_en_o
//  rd_cnt_o       out  32          granted reads
//  wr_cnt_o       out  32          granted writes
//  stall_cnt_o    out  32          cycles with req=1 and gnt=0
// BEHAVIOUR
//  - Reset: state IDLE, wait counter 0, LFSR = LFSR_SEED, rvalid/err/counters 0; data_rdata_o reads 0.
//  - LFSR: 16-bit Fibonacci, taps 16,14,13,11, shifts every cycle; draw = GNT_STALL_EN ? lfsr % (MAX_STALL+1) : 0.
//  - IDLE: req=1 & draw=0 -> gnt=1 this cycle, stay IDLE. req=1 & draw>0 -> gnt=0, load cnt=draw-1, go WAIT.
//  - WAIT: gnt=0 while cnt>0, cnt decrements; cnt=0 -> gnt=1, go IDLE. Request fields must hold stable
//    until gnt; req dropping in WAIT is a protocol violation (assertion fires, state returns IDLE).
//  - Out of range: oor = |data_addr_i[31:ADDR_WIDTH]| (0 when ADDR_WIDTH=32).
//  - ram_en_o = gnt & ~oor; RAM field outputs are pure pass-through, no RAM access without ram_en_o.
//  - Response latency exactly 1: rvalid registered = gnt of previous cycle; err registered = oor; is_read
//    registered = ~we & ~oor. data_rdata_o = (rvalid & is_read) ? ram_rdata_i : 0.
//  - Writes and errors still produce exactly one rvalid. Back-to-back grants legal every cycle; rvalid of
//    txn N and gnt of txn N+1 coincide. No response buffering: the core always accepts rvalid.
//  - Counters increment on gnt (rd if ~we, wr if we, errors included) or on req&~gnt (stall); wrap at 2**32.
//  - Reset mid-WAIT: pending request dropped, no gnt, no RAM write, no rvalid after reset.
// TESTING
//  1. STALL_EN=0: write 0xDEADBEEF be=F @0x100, read @0x100 -> gnt in req cycle, rvalid +1, rdata 0xDEADBEEF, rd=wr=1.
//  2. Mem 0 @0x200; write 0x11223344 be=4'b0101; read -> rdata 0x00220044.
//  3. STALL_EN=1, MAX_STALL=3: 200 random rd/wr vs scoreboard -> data match, each gnt wait <=3, stall_cnt = sum of waits.
//  4. ADDR_WIDTH=16: read @0x0001_0000 -> gnt, ram_en_o=0, rvalid+err next cycle, rdata 0, RAM unchanged.
//  5. rst_ni low during WAIT of a write -> no gnt/ram_en, outputs at reset values; next access completes normally.
//  6. STALL_EN=0, req held 4 cycles (rd,wr,rd,rd) -> 4 consecutive gnts, 4 consecutive rvalids lagging 1 cycle.

Source files
------------

// File: rtl/obi_dmem_bridge.sv
// OBI data-channel front end for the bench data RAM.
// Injects LFSR-driven grant stalls, flags out-of-range addresses and counts traffic.
module obi_dmem_bridge #(
   parameter int          ADDR_WIDTH   = 22,
   parameter bit          GNT_STALL_EN = 1'b1,
   parameter int          MAX_STALL    = 3,
   parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  data_req_i,
   output logic                  data_gnt_o,
   input  logic [31:0]           data_addr_i,
   input  logic                  data_we_i,
   input  logic [3:0]            data_be_i,
   input  logic [31:0]           data_wdata_i,
   output logic                  data_rvalid_o,
   output logic [31:0]           data_rdata_o,
   output logic                  data_err_o,
   output logic                  ram_en_o,
   output logic [ADDR_WIDTH-1:0] ram_addr_o,
   output logic [31:0]           ram_wdata_o,
   output logic                  ram_we_o,
   output logic [3:0]            ram_be_o,
   input  logic [31:0]           ram_rdata_i,
   output logic [31:0]           rd_cnt_o,
   output logic [31:0]           wr_cnt_o,
   output logic [31:0]           stall_cnt_o
);

   typedef enum logic {IDLE, WAIT} state_t;

   localparam logic [15:0] SEED = (LFSR_SEED == 16'h0) ? 16'h0001 : LFSR_SEED;
   localparam logic [15:0] MOD  = 16'(MAX_STALL + 1);

   state_t      state_q;
   logic [3:0]  cnt_q;
   logic [15:0] lfsr_q;
   logic        lfsr_fb;
   logic [3:0]  draw;
   logic        gnt;
   logic        oor;
   logic        rvalid_q;
   logic        err_q;
   logic        is_read_q;
   logic [31:0] rd_cnt_q;
   logic [31:0] wr_cnt_q;
   logic [31:0] stall_cnt_q;

   assign lfsr_fb = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
   assign draw    = GNT_STALL_EN ? 4'(lfsr_q % MOD) : 4'd0;

   generate
      if (ADDR_WIDTH < 32) begin : g_oor
         assign oor = |data_addr_i[31:ADDR_WIDTH];
      end else begin : g_no_oor
         assign oor = 1'b0;
      end
   endgenerate

   // Grant decision; held low while reset is asserted so no transfer leaks out.
   always_comb begin
      gnt = 1'b0;
      if (rst_ni && data_req_i) begin
         unique case (1'b1)
            (state_q == IDLE): gnt = (draw == 4'd0);
            (state_q == WAIT): gnt = (cnt_q == 4'd0);
            default:           gnt = 1'b0;
         endcase
      end
   end

   assign data_gnt_o  = gnt;
   assign ram_en_o    = gnt & ~oor;
   assign ram_addr_o  = data_addr_i[ADDR_WIDTH-1:0];
   assign ram_wdata_o = data_wdata_i;
   assign ram_we_o    = data_we_i;
   assign ram_be_o    = data_be_i;

   // Stall FSM: a nonzero draw parks the request in WAIT for draw cycles total.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
      end else begin
         case (state_q)
            IDLE: begin
               if (data_req_i && draw != 4'd0) begin
                  state_q <= WAIT;
                  cnt_q   <= draw - 4'd1;
               end
            end
            WAIT: begin
               if (!data_req_i || cnt_q == 4'd0) begin
                  state_q <= IDLE;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Free-running stall LFSR.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         lfsr_q <= SEED;
      end else begin
         lfsr_q <= {lfsr_fb, lfsr_q[15:1]};
      end
   end

   // One-cycle response pipeline: every grant yields exactly one rvalid.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rvalid_q  <= 1'b0;
         err_q     <= 1'b0;
         is_read_q <= 1'b0;
      end else begin
         rvalid_q  <= gnt;
         err_q     <= gnt & oor;
         is_read_q <= gnt & ~data_we_i & ~oor;
      end
   end

   assign data_rvalid_o = rvalid_q;
   assign data_err_o    = err_q;
   assign data_rdata_o  = (rvalid_q && is_read_q) ? ram_rdata_i : 32'h0;

   // Traffic counters for test reporting; wrap naturally.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rd_cnt_q    <= 32'h0;
         wr_cnt_q    <= 32'h0;
         stall_cnt_q <= 32'h0;
      end else begin
         if (gnt && !data_we_i) rd_cnt_q <= rd_cnt_q + 32'd1;
         if (gnt && data_we_i)  wr_cnt_q <= wr_cnt_q + 32'd1;
         if (data_req_i && !gnt) stall_cnt_q <= stall_cnt_q + 32'd1;
      end
   end

   assign rd_cnt_o    = rd_cnt_q;
   assign wr_cnt_o    = wr_cnt_q;
   assign stall_cnt_o = stall_cnt_q;

   a_req_held: assert property (
      @(posedge clk_i) disable iff (!rst_ni)
      (state_q == WAIT) |-> data_req_i
   );

endmodule
